// File: rtl/vedic8_pipe.sv
// 8x8 unsigned Vedic (urdhva) multiplier, 2-stage valid/ready pipeline with a sideband tag.
// Define VEDIC8_OUT_REG_EN to add a third (output register) stage, giving latency 3.
module vedic8_pipe #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       a,
   input  logic [7:0]       b,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [15:0]      p,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_valid,
   input  logic             out_ready
);

   // 4-bit ripple-carry slice; every wider adder here is a chain of these.
   function automatic logic [4:0] add4(input logic [3:0] x, input logic [3:0] y, input logic ci);
      logic [4:0] r;
      logic       c;
      r = '0;
      c = ci;
      for (int i = 0; i < 4; i++) begin
         r[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      r[4] = c;
      return r;
   endfunction

   function automatic logic [8:0] add8(input logic [7:0] x, input logic [7:0] y);
      logic [4:0] lo;
      logic [4:0] hi;
      lo = add4(x[3:0], y[3:0], 1'b0);
      hi = add4(x[7:4], y[7:4], lo[4]);
      return {hi, lo[3:0]};
   endfunction

   // The product never exceeds 0xFE01, so the last slice's carry is always zero.
   function automatic logic [15:0] add16(input logic [15:0] x, input logic [15:0] y);
      logic [4:0] s0;
      logic [4:0] s1;
      logic [4:0] s2;
      logic [4:0] s3;
      s0 = add4(x[3:0],   y[3:0],   1'b0);
      s1 = add4(x[7:4],   y[7:4],   s0[4]);
      s2 = add4(x[11:8],  y[11:8],  s1[4]);
      s3 = add4(x[15:12], y[15:12], s2[4]);
      return {s3[3:0], s2[3:0], s1[3:0], s0[3:0]};
   endfunction

   function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
      logic t1;
      logic t2;
      logic c1;
      logic hh;
      t1 = x[1] & y[0];
      t2 = x[0] & y[1];
      c1 = t1 & t2;
      hh = x[1] & y[1];
      return {hh & c1, hh ^ c1, t1 ^ t2, x[0] & y[0]};
   endfunction

   // 4x4 built from the same urdhva split one level down (2x2 sub-products).
   function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
      logic [3:0] m0;
      logic [3:0] m1;
      logic [3:0] m2;
      logic [3:0] m3;
      logic [4:0] mid;
      logic [8:0] sum;
      m0  = mul2(x[1:0], y[1:0]);
      m1  = mul2(x[3:2], y[1:0]);
      m2  = mul2(x[1:0], y[3:2]);
      m3  = mul2(x[3:2], y[3:2]);
      mid = add4(m1, m2, 1'b0);
      sum = add8({m3, m0}, {1'b0, mid, 2'b00});
      return sum[7:0];
   endfunction

   logic [7:0]       q0_p0, q1_p0, q2_p0, q3_p0;
   logic [7:0]       q0_p1, q1_p1, q2_p1, q3_p1;
   logic [TAG_W-1:0] tag_p1;
   logic             vld_p1;
   logic [8:0]       mid_p1;
   logic [15:0]      prod_p1;
   logic [15:0]      p_p2;
   logic [TAG_W-1:0] tag_p2;
   logic             vld_p2;
   logic             adv_p2;

   always_comb begin
      q0_p0 = mul4(a[3:0], b[3:0]);
      q1_p0 = mul4(a[7:4], b[3:0]);
      q2_p0 = mul4(a[3:0], b[7:4]);
      q3_p0 = mul4(a[7:4], b[7:4]);
   end

   assign in_ready = !vld_p1 || adv_p2;

   // Stage 1: register the four sub-products and the tag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         q0_p1  <= '0;
         q1_p1  <= '0;
         q2_p1  <= '0;
         q3_p1  <= '0;
         tag_p1 <= '0;
      end else if (in_ready) begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            q0_p1  <= q0_p0;
            q1_p1  <= q1_p0;
            q2_p1  <= q2_p0;
            q3_p1  <= q3_p0;
            tag_p1 <= in_tag;
         end
      end
   end

   // q0 and q3<<8 do not overlap, so they concatenate; the 9-bit cross sum lands at bit 4.
   always_comb begin
      mid_p1  = add8(q1_p1, q2_p1);
      prod_p1 = add16({q3_p1, q0_p1}, {3'b000, mid_p1, 4'b0000});
   end

   // Stage 2: register the 16-bit product.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p2 <= 1'b0;
         p_p2   <= '0;
         tag_p2 <= '0;
      end else if (adv_p2) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            p_p2   <= prod_p1;
            tag_p2 <= tag_p1;
         end
      end
   end

`ifdef VEDIC8_OUT_REG_EN
   logic [15:0]      p_p3;
   logic [TAG_W-1:0] tag_p3;
   logic             vld_p3;
   logic             adv_p3;

   assign adv_p3 = !vld_p3 || out_ready;
   assign adv_p2 = !vld_p2 || adv_p3;

   // Stage 3: optional output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p3 <= 1'b0;
         p_p3   <= '0;
         tag_p3 <= '0;
      end else if (adv_p3) begin
         vld_p3 <= vld_p2;
         if (vld_p2) begin
            p_p3   <= p_p2;
            tag_p3 <= tag_p2;
         end
      end
   end

   assign p         = p_p3;
   assign out_tag   = tag_p3;
   assign out_valid = vld_p3;
`else
   assign adv_p2    = !vld_p2 || out_ready;
   assign p         = p_p2;
   assign out_tag   = tag_p2;
   assign out_valid = vld_p2;
`endif

endmodule

// File: tb/tb_vedic8_pipe.sv
// Self-checking bench for vedic8_pipe: directed scenarios plus a random scoreboard run.
// Honours VEDIC8_OUT_REG_EN to expect the 3-stage latency.
module tb_vedic8_pipe;
   localparam int TAG_W = 4;
`ifdef VEDIC8_OUT_REG_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [7:0]       a;
   logic [7:0]       b;
   logic [TAG_W-1:0] in_tag;
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      p;
   logic [TAG_W-1:0] out_tag;
   logic             out_valid;
   logic             out_ready;

   typedef struct packed {
      logic [15:0]      p;
      logic [TAG_W-1:0] tag;
   } item_t;

   item_t exp_q[$];
   item_t obs_q[$];
   int    errors = 0;
   int    checks = 0;

   vedic8_pipe #(.TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .in_tag(in_tag), .in_valid(in_valid),
      .in_ready(in_ready), .p(p), .out_tag(out_tag), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   // Inputs change 1ns after posedge, so values seen at negedge are what the next edge samples.
   always @(negedge clk) begin
      item_t it;
      if (!rst) begin
         if (in_valid && in_ready) begin
            it.p   = {8'h00, a} * {8'h00, b};
            it.tag = in_tag;
            exp_q.push_back(it);
         end
         if (out_valid && out_ready) begin
            it.p   = p;
            it.tag = out_tag;
            obs_q.push_back(it);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [7:0] va, input logic [7:0] vb,
                         input logic [TAG_W-1:0] vt, input logic vv);
      a        = va;
      b        = vb;
      in_tag   = vt;
      in_valid = vv;
   endtask

   task automatic drain(output bit timeout);
      int idle;
      idle      = 0;
      timeout   = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (!out_valid && obs_q.size() == exp_q.size()) idle++;
         else idle = 0;
         if (idle > LAT + 1) begin
            timeout = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_in(8'h00, 8'h00, '0, 1'b0);
      out_ready = 1'b1;
      repeat (3) tick();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready_during: got %b want 1", in_ready);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      checks++;
      if (p !== 16'h0000) begin
         errors++;
         $display("FAIL reset_p: got %h want 0000", p);
      end
      checks++;
      if (out_tag !== '0) begin
         errors++;
         $display("FAIL reset_out_tag: got %h want 0", out_tag);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready_after: got %b want 1", in_ready);
      end
   endtask

   task automatic test_max();
      bit    to;
      item_t e, o;
      out_ready = 1'b1;
      set_in(8'hFF, 8'hFF, 4'd3, 1'b1);
      tick();
      set_in(8'h00, 8'h00, '0, 1'b0);
      repeat (LAT - 2) tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL max_early_valid: got %b want 0", out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || p !== 16'hFE01 || out_tag !== 4'd3) begin
         errors++;
         $display("FAIL max_product: got v=%b p=%h tag=%h want v=1 p=fe01 tag=3", out_valid, p, out_tag);
      end
      drain(to);
      checks++;
      if (to) begin
         errors++;
         $display("FAIL max_drain: timed out exp=%0d obs=%0d", exp_q.size(), obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL max_sb: got p=%h tag=%h want p=%h tag=%h", o.p, o.tag, e.p, e.tag);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_back_to_back();
      bit    to;
      item_t e, o;
      out_ready = 1'b1;
      set_in(8'h0F, 8'hF0, 4'd1, 1'b1);
      tick();
      set_in(8'h12, 8'h34, 4'd2, 1'b1);
      tick();
      set_in(8'h00, 8'h00, '0, 1'b0);
      repeat (LAT - 2) tick();
      checks++;
      if (out_valid !== 1'b1 || p !== 16'h0E10 || out_tag !== 4'd1) begin
         errors++;
         $display("FAIL b2b_first: got v=%b p=%h tag=%h want v=1 p=0e10 tag=1", out_valid, p, out_tag);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || p !== 16'h03A8 || out_tag !== 4'd2) begin
         errors++;
         $display("FAIL b2b_second: got v=%b p=%h tag=%h want v=1 p=03a8 tag=2", out_valid, p, out_tag);
      end
      drain(to);
      checks++;
      if (to || obs_q.size() != 2) begin
         errors++;
         $display("FAIL b2b_count: timeout=%b obs=%0d want 2", to, obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL b2b_sb: got p=%h tag=%h want p=%h tag=%h", o.p, o.tag, e.p, e.tag);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_stall();
      logic [7:0] sa[4] = '{8'h11, 8'h33, 8'h55, 8'h77};
      logic [7:0] sb[4] = '{8'h22, 8'h44, 8'h66, 8'h88};
      int    k;
      bit    acc, to;
      item_t e, o;
      k         = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (k < 4) set_in(sa[k], sb[k], k[TAG_W-1:0], 1'b1);
         else set_in(8'h00, 8'h00, '0, 1'b0);
         #1;
         acc = in_valid && in_ready;
         tick();
         if (acc) k++;
      end
      checks++;
      if (k != LAT) begin
         errors++;
         $display("FAIL stall_accepts: got %0d want %0d", k, LAT);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL stall_in_ready: got %b want 0", in_ready);
      end
      checks++;
      if (out_valid !== 1'b1 || p !== 16'h0242 || out_tag !== 4'd0) begin
         errors++;
         $display("FAIL stall_hold: got v=%b p=%h tag=%h want v=1 p=0242 tag=0", out_valid, p, out_tag);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 20 && k < 4; c++) begin
         set_in(sa[k], sb[k], k[TAG_W-1:0], 1'b1);
         #1;
         acc = in_valid && in_ready;
         tick();
         if (acc) k++;
      end
      drain(to);
      checks++;
      if (to || obs_q.size() != 4) begin
         errors++;
         $display("FAIL stall_count: timeout=%b obs=%0d want 4", to, obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL stall_sb: got p=%h tag=%h want p=%h tag=%h", o.p, o.tag, e.p, e.tag);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_zero_one();
      bit    to;
      item_t o;
      out_ready = 1'b1;
      set_in(8'h00, 8'hAB, 4'd6, 1'b1);
      tick();
      set_in(8'h01, 8'hAB, 4'd7, 1'b1);
      tick();
      drain(to);
      checks++;
      if (to || obs_q.size() != 2) begin
         errors++;
         $display("FAIL zero_one_count: timeout=%b obs=%0d want 2", to, obs_q.size());
      end
      if (obs_q.size() >= 2) begin
         o = obs_q.pop_front();
         checks++;
         if (o.p !== 16'h0000 || o.tag !== 4'd6) begin
            errors++;
            $display("FAIL zero_prod: got p=%h tag=%h want p=0000 tag=6", o.p, o.tag);
         end
         o = obs_q.pop_front();
         checks++;
         if (o.p !== 16'h00AB || o.tag !== 4'd7) begin
            errors++;
            $display("FAIL one_prod: got p=%h tag=%h want p=00ab tag=7", o.p, o.tag);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset_midflight();
      bit    to, pulse;
      item_t e, o;
      out_ready = 1'b0;
      set_in(8'h21, 8'h43, 4'd1, 1'b1);
      tick();
      set_in(8'h65, 8'h87, 4'd2, 1'b1);
      tick();
      set_in(8'h00, 8'h00, '0, 1'b0);
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || p !== 16'h0000 || out_tag !== '0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midrst_async: got v=%b p=%h tag=%h rdy=%b want v=0 p=0000 tag=0 rdy=1",
                  out_valid, p, out_tag, in_ready);
      end
      tick();
      tick();
      rst = 1'b0;
      exp_q.delete();
      obs_q.delete();
      out_ready = 1'b1;
      pulse     = 1'b0;
      repeat (4) begin
         tick();
         if (out_valid !== 1'b0) pulse = 1'b1;
      end
      checks++;
      if (pulse) begin
         errors++;
         $display("FAIL midrst_pulse: got out_valid=1 after reset want 0");
      end
      set_in(8'h80, 8'h02, 4'd9, 1'b1);
      tick();
      set_in(8'h00, 8'h00, '0, 1'b0);
      repeat (LAT - 1) tick();
      checks++;
      if (out_valid !== 1'b1 || p !== 16'h0100 || out_tag !== 4'd9) begin
         errors++;
         $display("FAIL midrst_first: got v=%b p=%h tag=%h want v=1 p=0100 tag=9", out_valid, p, out_tag);
      end
      drain(to);
      checks++;
      if (to || obs_q.size() != 1) begin
         errors++;
         $display("FAIL midrst_count: timeout=%b obs=%0d want 1", to, obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL midrst_sb: got p=%h tag=%h want p=%h tag=%h", o.p, o.tag, e.p, e.tag);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_random();
      int    sent, pairs;
      bit    acc, to;
      item_t e, o;
      sent  = 0;
      pairs = 0;
      for (int c = 0; c < 60000 && sent < 10000; c++) begin
         out_ready = ($urandom_range(3) != 0);
         set_in(8'($urandom), 8'($urandom), TAG_W'($urandom), $urandom_range(3) != 0);
         #1;
         acc = in_valid && in_ready;
         tick();
         if (acc) sent++;
      end
      drain(to);
      checks++;
      if (to || sent != 10000 || obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL rand_count: timeout=%b sent=%0d obs=%0d exp=%0d", to, sent, obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         pairs++;
         checks++;
         if (o !== e) begin
            errors++;
            if (errors < 20)
               $display("FAIL rand_sb[%0d]: got p=%h tag=%h want p=%h tag=%h", pairs, o.p, o.tag, e.p, e.tag);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   initial begin
      rst       = 1'b1;
      a         = '0;
      b         = '0;
      in_tag    = '0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      test_reset();
      test_max();
      test_back_to_back();
      test_stall();
      test_zero_one();
      test_reset_midflight();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
